seq_alu: RTL and testbench

Parametrised, multi-cycle arithmetic unit: add, subtract, multiply, divide (quotient + remainder) and three-way compare on WIDTH-bit unsigned operands, behind valid/ready handshakes on both sides. Single-cycle ops finish one edge after acceptance. Multiply and divide run iterative shift-add and restoring-division datapaths over WIDTH cycles, which keeps area small. It sits between the instruction decoder (command side) and the register writeback (result side), and adds carry, zero, compare and error flags.

---
 rtl/seq_alu_if.sv | 11 +
 rtl/seq_alu.sv | 91 +++++++++
 tb/tb_seq_alu.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: command/result handshake bundle between the decoder, seq_alu and register writeback
interface seq_alu_if #(parameter int WIDTH = 8);
   logic in_valid, in_ready, out_valid, out_ready;
   logic [2:0] op;
   logic [WIDTH-1:0] a, b, result_lo, result_hi;
   logic flag_zero, flag_carry, flag_cmp, flag_err;
   modport master(output in_valid, op, a, b, out_ready,
                  input in_ready, out_valid, result_lo, result_hi, flag_zero, flag_carry, flag_cmp, flag_err);
   modport slave(input in_valid, op, a, b, out_ready,
                 output in_ready, out_valid, result_lo, result_hi, flag_zero, flag_carry, flag_cmp, flag_err);
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle unsigned ALU with valid/ready handshakes; iterative MUL/DIV present only when SEQ_ALU_MULDIV_EN is defined
module seq_alu #(parameter int WIDTH = 8) (
   input logic clk,
   input logic rst,
   seq_alu_if.slave bus
);
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3;
   localparam logic [2:0] OP_EQ = 3'd4, OP_GT = 3'd5, OP_LT = 3'd6, OP_RSV = 3'd7;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] res_lo, res_hi, imm_lo;
   logic [WIDTH:0] sum, diff;
   logic f_zero, f_carry, f_cmp, f_err;
   logic accept, go_busy, last, cmp, imm_carry, imm_err;
   assign bus.in_ready = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.result_lo = res_lo;
   assign bus.result_hi = res_hi;
   assign {bus.flag_zero, bus.flag_carry, bus.flag_cmp, bus.flag_err} = {f_zero, f_carry, f_cmp, f_err};
   assign accept = bus.in_valid && state == IDLE;
   always_comb begin
      sum = {1'b0, bus.a} + {1'b0, bus.b};
      diff = {1'b0, bus.a} - {1'b0, bus.b};
      cmp = bus.op == OP_EQ ? bus.a == bus.b : bus.op == OP_GT ? bus.a > bus.b : bus.op == OP_LT && bus.a < bus.b;
      imm_lo = bus.op == OP_ADD ? sum[WIDTH-1:0] : bus.op == OP_SUB ? diff[WIDTH-1:0] : {{(WIDTH-1){1'b0}}, cmp};
      imm_carry = bus.op == OP_ADD ? sum[WIDTH] : bus.op == OP_SUB && diff[WIDTH];
`ifdef SEQ_ALU_MULDIV_EN
      imm_err = bus.op == OP_RSV || (bus.op == OP_DIV && bus.b == '0);
      go_busy = bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != '0);
`else
      imm_err = bus.op == OP_RSV || bus.op == OP_MUL || bus.op == OP_DIV;
      go_busy = 1'b0;
`endif
      state_nx = state == IDLE ? (accept ? (go_busy ? BUSY : DONE) : IDLE) :
                 state == BUSY ? (last ? DONE : BUSY) : (bus.out_ready ? IDLE : DONE);
   end
`ifdef SEQ_ALU_MULDIV_EN
   localparam int CW = $clog2(WIDTH + 1);
   logic [2*WIDTH-1:0] acc, step;
   logic [WIDTH-1:0] d, div_r;
   logic [WIDTH:0] mul_sum, div_hi;
   logic [CW-1:0] cnt;
   logic is_div, div_ge;
   assign last = cnt == CW'(1);
   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
      div_hi = acc[2*WIDTH-1:WIDTH-1];
      div_ge = div_hi >= {1'b0, d};
      div_r = div_ge ? WIDTH'(div_hi - {1'b0, d}) : div_hi[WIDTH-1:0];
      step = is_div ? {div_r, acc[WIDTH-2:0], div_ge} : {mul_sum, acc[WIDTH-1:1]};
   end
   always_ff @(posedge clk)
      if (accept) begin
         acc <= {{WIDTH{1'b0}}, bus.op == OP_DIV ? bus.a : bus.b};
         d <= bus.op == OP_DIV ? bus.b : bus.a;
         is_div <= bus.op == OP_DIV;
         cnt <= CW'(WIDTH);
      end else if (state == BUSY) begin
         acc <= step;
         cnt <= cnt - 1'b1;
      end
`else
   assign last = 1'b1;
`endif
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         res_lo <= '0;
         res_hi <= '0;
         {f_zero, f_carry, f_cmp, f_err} <= '0;
      end else begin
         state <= state_nx;
         if (accept && !go_busy) begin
            res_lo <= imm_lo;
            res_hi <= '0;
            f_zero <= imm_lo == '0;
            f_carry <= imm_carry;
            f_cmp <= cmp;
            f_err <= imm_err;
         end
`ifdef SEQ_ALU_MULDIV_EN
         if (state == BUSY && last) begin
            res_lo <= step[WIDTH-1:0];
            res_hi <= step[2*WIDTH-1:WIDTH];
            f_zero <= is_div ? step[WIDTH-1:0] == '0 : step == '0;
            {f_carry, f_cmp, f_err} <= '0;
         end
`endif
      end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with literal expectations plus a transaction-level scoreboard checked every cycle
module tb_seq_alu;
   localparam int W = 8;
`ifdef SEQ_ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif
   typedef struct packed {
      logic [W-1:0] lo, hi;
      logic z, c, cmp, err;
      logic [7:0] lat;
   } res_t;
   logic clk = 1'b0, rst = 1'b1;
   int n_cmp = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
   seq_alu_if #(.WIDTH(W)) bus();
   seq_alu #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, want);
      end
   endtask
   // expected outcome of one command, straight from the arithmetic rules
   function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      res_t r = '0;
      int s;
      if (o == 3'd0) begin
         s = int'(x) + int'(y);
         r.lo = W'(s % 256);
         r.c = s > 255;
      end else if (o == 3'd1) begin
         r.lo = W'((int'(x) - int'(y) + 256) % 256);
         r.c = x < y;
      end else if (o == 3'd2 && MD) begin
         s = int'(x) * int'(y);
         r.lo = W'(s % 256);
         r.hi = W'(s / 256);
         r.lat = 8'(W);
      end else if (o == 3'd3 && MD && y != 0) begin
         r.lo = x / y;
         r.hi = x % y;
         r.lat = 8'(W);
      end else if (o >= 3'd4 && o <= 3'd6) begin
         r.cmp = o == 3'd4 ? x == y : o == 3'd5 ? x > y : x < y;
         r.lo = W'(r.cmp);
      end else r.err = 1'b1;
      r.z = o == 3'd2 ? r.lo == 0 && r.hi == 0 : r.lo == 0;
      return r;
   endfunction
   res_t m_exp = '0, pend = '0;
   int m_state = 0, m_cnt = 0;
   bit m_live = 1'b0;
   always @(negedge clk) begin
      if (m_live) begin
         chk("sb.in_ready", bus.in_ready, m_state == 0);
         chk("sb.out_valid", bus.out_valid, m_state == 2);
         chk("sb.result_lo", bus.result_lo, m_exp.lo);
         chk("sb.result_hi", bus.result_hi, m_exp.hi);
         chk("sb.flags", {bus.flag_zero, bus.flag_carry, bus.flag_cmp, bus.flag_err}, {m_exp.z, m_exp.c, m_exp.cmp, m_exp.err});
      end
      if (rst) begin
         m_live = 1'b1;
         m_state = 0;
         m_exp = '0;
      end else if (m_state == 0 && bus.in_valid) begin
         pend = model(bus.op, bus.a, bus.b);
         if (pend.lat == 0) begin
            m_exp = pend;
            m_state = 2;
         end else begin
            m_cnt = int'(pend.lat);
            m_state = 1;
         end
      end else if (m_state == 1) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_exp = pend;
            m_state = 2;
         end
      end else if (m_state == 2 && bus.out_ready) m_state = 0;
   end
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int i = 0;
      bus.in_valid = 1'b1;
      bus.op = o;
      bus.a = x;
      bus.b = y;
      @(negedge clk);
      while (!bus.in_ready && i < 50) begin
         @(negedge clk);
         i++;
      end
      chk("issue.in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1 acc_cyc = cyc;
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_valid(input string nm);
      int n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, ".out_valid"}, bus.out_valid, 1);
   endtask
   task automatic run(input string nm, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input int lat, input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [3:0] fl);
      issue(o, x, y);
      wait_valid(nm);
      chk({nm, ".latency"}, cyc - acc_cyc, lat);
      chk({nm, ".result_lo"}, bus.result_lo, lo);
      chk({nm, ".result_hi"}, bus.result_hi, hi);
      chk({nm, ".flags"}, {bus.flag_zero, bus.flag_carry, bus.flag_cmp, bus.flag_err}, fl);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int seen;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.op = 3'd0;
      bus.a = '0;
      bus.b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset.out_valid", bus.out_valid, 0);
      chk("reset.in_ready", bus.in_ready, 1);
      chk("reset.results", {bus.result_hi, bus.result_lo}, 0);
      chk("reset.flags", {bus.flag_zero, bus.flag_carry, bus.flag_cmp, bus.flag_err}, 0);
      @(posedge clk);
      #1;
      run("add_carry", 3'd0, 8'd200, 8'd100, 0, 8'h2C, 8'h00, 4'b0100);
      run("sub_borrow", 3'd1, 8'd5, 8'd7, 0, 8'hFE, 8'h00, 4'b0100);
      run("sub_plain", 3'd1, 8'd9, 8'd4, 0, 8'h05, 8'h00, 4'b0000);
      run("add_zero", 3'd0, 8'd0, 8'd0, 0, 8'h00, 8'h00, 4'b1000);
      run("cmp_gt", 3'd5, 8'd3, 8'd250, 0, 8'h00, 8'h00, 4'b1000);
      run("cmp_lt", 3'd6, 8'd3, 8'd250, 0, 8'h01, 8'h00, 4'b0010);
      run("cmp_eq", 3'd4, 8'd9, 8'd9, 0, 8'h01, 8'h00, 4'b0010);
      run("reserved", 3'd7, 8'd1, 8'd2, 0, 8'h00, 8'h00, 4'b1001);
`ifdef SEQ_ALU_MULDIV_EN
      run("mul_max", 3'd2, 8'd255, 8'd255, 8, 8'h01, 8'hFE, 4'b0000);
      run("mul_zero", 3'd2, 8'd0, 8'd9, 8, 8'h00, 8'h00, 4'b1000);
      run("div", 3'd3, 8'd200, 8'd7, 8, 8'h1C, 8'h04, 4'b0000);
      run("div_small", 3'd3, 8'd3, 8'd7, 8, 8'h00, 8'h03, 4'b1000);
      run("div_by_zero", 3'd3, 8'd50, 8'd0, 0, 8'h00, 8'h00, 4'b1001);
`else
      run("mul_off", 3'd2, 8'd2, 8'd3, 0, 8'h00, 8'h00, 4'b1001);
      run("div_off", 3'd3, 8'd200, 8'd7, 0, 8'h00, 8'h00, 4'b1001);
`endif
      issue(3'd3, 8'd200, 8'd7);
      wait_valid("bp");
      bus.in_valid = 1'b1;
      bus.op = 3'd0;
      bus.a = 8'd1;
      bus.b = 8'd1;
      for (int i = 0; i < 5; i++) begin
         chk("bp.in_ready", bus.in_ready, 0);
         chk("bp.out_valid", bus.out_valid, 1);
         chk("bp.result_lo", bus.result_lo, MD ? 8'h1C : 8'h00);
         chk("bp.flag_err", bus.flag_err, !MD);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      chk("bp.handoff_in_ready", bus.in_ready, 1);
      chk("bp.handoff_out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp.next_out_valid", bus.out_valid, 1);
      chk("bp.next_result_lo", bus.result_lo, 8'h02);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.op = 3'd0;
      bus.a = 8'd10;
      bus.b = 8'd20;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1 if (i == 7) bus.in_valid = 1'b0;
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("tput.results_in_8", seen, 4);
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      issue(3'd2, 8'd7, 8'd9);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
`else
      issue(3'd0, 8'd1, 8'd1);
      @(posedge clk);
      #1 rst = 1'b1;
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid.out_valid", bus.out_valid, 0);
      chk("rst_mid.in_ready", bus.in_ready, 1);
      chk("rst_mid.result_lo", bus.result_lo, 0);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("rst_mid.no_result", seen, 0);
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
